// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: 8N1 UART receiver sequencing a shared baud counter, valid/ready byte output
module uart_rx_ctrl #(
  parameter int DATA_BITS   = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 rx,
  input  logic                 half_bit_flag,
  output logic                 cnt_reset,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun_err,
  output logic                 busy
);
  localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [IW-1:0] LAST = IW'(DATA_BITS - 1);
  localparam logic [1:0] IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3;
  logic [1:0]             state;
  logic [SYNC_STAGES-1:0] sync;
  logic                   rx_s, rx_d, good;
  logic [DATA_BITS-1:0]   shreg;
  logic [IW-1:0]          bit_idx;
  assign rx_s      = sync[SYNC_STAGES-1];
  assign cnt_reset = state == IDLE;
  assign busy      = state != IDLE;
  assign good      = state == STOP && half_bit_flag && rx_s;
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state       <= IDLE;
      sync        <= '1;
      rx_d        <= 1'b1;
      shreg       <= '0;
      bit_idx     <= '0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      sync        <= {sync[SYNC_STAGES-2:0], rx};
      rx_d        <= rx_s;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
      if (rx_valid && rx_ready) rx_valid <= 1'b0;
      // an accept in the completion cycle frees the slot for the new byte
      if (good) begin
        if (!rx_valid || rx_ready) begin
          rx_data  <= shreg;
          rx_valid <= 1'b1;
        end else overrun_err <= 1'b1;
      end
      case (state)
        IDLE:  if (rx_d && !rx_s) state <= START;
        START: if (half_bit_flag) begin
          state   <= rx_s ? IDLE : DATA;
          bit_idx <= '0;
        end
        DATA:  if (half_bit_flag) begin
          shreg[bit_idx] <= rx_s;
          if (bit_idx == LAST) state <= STOP;
          else bit_idx <= bit_idx + IW'(1);
        end
        STOP:  if (half_bit_flag) begin
          state     <= IDLE;
          frame_err <= !rx_s;
        end
      endcase
    end
  end
endmodule

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

UART receive controller that sequences the shared baud/bit counter to deserialize 8N1 frames from the `rx` pin. It synchronizes the line, detects the start edge, and releases the counter via `cnt_reset`. It samples each bit on the counter's `half_bit_flag`, checks the stop bit, and presents bytes on a valid/ready interface to the downstream consumer. It sits between the board RX pin / baud counter and the command/loopback logic on the DE10.

## Interface
- `DATA_BITS`, 8, payload bits per frame, LSB first.
- `SYNC_STAGES`, 2, flip-flop stages on `rx` before use (≥2).

- `clk`  in  1  system clock (50 MHz).
- `rstn`  in  1  reset. One clock; reset is synchronous and active-low.
- `rx`  in  1  asynchronous serial line, idle high.
- `half_bit_flag`  in  1  single-cycle pulse from the baud counter at mid-bit; first pulse 217 cycles after `cnt_reset` falls, then every 435 cycles.
- `cnt_reset`  out  1  holds the baud counter at 0 while high.
- `rx_data`  out  DATA_BITS  received byte, stable while `rx_valid`.
- `rx_valid`  out  1  byte available.
- `rx_ready`  in  1  consumer accepts byte when `rx_valid && rx_ready`.
- `frame_err`  out  1  one-cycle pulse: stop bit sampled low.
- `overrun_err`  out  1  one-cycle pulse: byte completed while the previous one was still held.
- `busy`  out  1  high in any state except IDLE.

## Operation
- Input path: `rx` → SYNC_STAGES flops → `rx_s`. A further flop gives `rx_d`. All of these reset to 1.
- FSM states: IDLE, START, DATA, STOP. Resets to IDLE.
- IDLE: `cnt_reset`=1. Fall detect (`rx_d`=1, `rx_s`=0) moves to START.
- START: `cnt_reset`=0. On `half_bit_flag`:
  - `rx_s`=0 moves to DATA with bit index 0.
  - `rx_s`=1 is a false start: return to IDLE with no output and no error.
- DATA: on each `half_bit_flag`, shift `rx_s` into the shift register at position `bit_idx` (LSB first) and increment `bit_idx`.
  - After bit DATA_BITS-1 is sampled, go to STOP.
  - `bit_idx` width is clog2(DATA_BITS). It is cleared on START→DATA and never wraps during a frame.
- STOP: on `half_bit_flag`, go to IDLE. `cnt_reset` reasserts the next cycle, re-arming mid stop bit.
  - `rx_s`=1: frame is good and goes to delivery.
  - `rx_s`=0: pulse `frame_err`. The byte is discarded and `rx_valid` is unaffected.
- Delivery of a good frame in cycle T:
  - If `rx_valid`=0, or `rx_valid && rx_ready` in T: load `rx_data` and set `rx_valid`=1 in T+1.
  - Else: pulse `overrun_err` in T+1. The new byte is dropped and `rx_data` keeps the old byte.
- Handshake: `rx_valid` falls in the cycle after `rx_valid && rx_ready`, unless a new byte loads in that same cycle. `rx_data` never changes while `rx_valid`=1 and `rx_ready`=0.
- `half_bit_flag` in IDLE is ignored.
- `frame_err` and `overrun_err` are mutually exclusive per frame.

## Timing
- Reset values: `cnt_reset`=1, `rx_data`=0, `rx_valid`=0, `frame_err`=0, `overrun_err`=0, `busy`=0. The shift register and `bit_idx` reset to 0.
- `rstn` low in any state forces all of the above on the next edge. A partial frame is discarded, and a held `rx_valid` byte is dropped.
- Start latency: `rx` falls at cycle 0, `rx_s` is low at cycle SYNC_STAGES, and the FSM is in START with `cnt_reset`=0 at SYNC_STAGES+1.
- Frame latency: `rx_valid` rises 1 cycle after the stop-bit `half_bit_flag`. That is ≈9.5 bit times (≈4133 cycles at 435/bit) after the start edge, plus the sync delay.
- Outputs are registered except `cnt_reset` and `busy`, which decode state directly.
- A start edge occurring while in START/DATA/STOP is ignored. The earliest next-frame detection is the first cycle back in IDLE.

## Test plan
- **Basic receive:** reset, then drive 0xA5 8N1 at 435 cycles/bit with `rx_ready`=1, paired with the baud counter. Required: `rx_data`=0xA5 and `rx_valid` high exactly 1 cycle; no errors; `busy` low after STOP.
- **Glitch rejection:** `rx` low for 100 cycles, then high. Required: START→IDLE at the first `half_bit_flag`; `rx_valid`, `frame_err` and `overrun_err` stay 0; `cnt_reset` returns to 1.
- **Framing error:** send 0x3C with the stop bit driven 0. Required: one `frame_err` pulse 1 cycle after the stop sample; `rx_valid` stays 0; next good frame 0x11 is received correctly.
- **Overrun:** `rx_ready`=0, send 0x12 then 0x34 back-to-back. Required:
  - `rx_data`=0x12 held with `rx_valid`=1.
  - One `overrun_err` pulse at the end of the second frame.
  - After `rx_ready`=1, 0x12 is consumed and `rx_valid` drops.
- **Accept/load collision:** hold 0x55 valid, and assert `rx_ready` in the exact completion cycle of 0xAA. Required: no overrun; `rx_valid` stays 1 and `rx_data`=0xAA next cycle.
- **Reset mid-frame:** pull `rstn` low during DATA bit 4 of 0xF0. Required: all outputs at reset values next cycle; no `rx_valid`; a subsequent 0x0F frame is received correctly.
